// File: rtl/trap_seq.sv
// ---------------------------------------------------------------------------
// trap_seq -- machine-mode trap / mret sequencer (CLINT side of the CSR file)
//
// Watches the instruction in ID plus the timer interrupt line. On an ecall,
// ebreak or an enabled timer interrupt it stalls the pipeline. It then writes
// mepc, mstatus and mcause through the CSR file's CLINT write port, one per
// cycle, and finally pulses a redirect to mtvec. On mret it rewrites mstatus
// and redirects to mepc.
//
// Ports
//   clk              clock, all state changes on the rising edge
//   rst              asynchronous active-low reset
//   inst_i           instruction currently in ID
//   inst_addr_i      PC of inst_i
//   timer_int_i      level-sensitive timer interrupt request
//   global_int_en_i  mstatus.MIE
//   csr_mtvec_i      current mtvec
//   csr_mepc_i       current mepc
//   csr_mstatus_i    current mstatus
//   we_o             CSR write enable
//   waddr_o          CSR write address (bits [11:0] only)
//   data_o           CSR write data
//   hold_flag_o      pipeline stall request
//   int_assert_o     one-cycle redirect strobe
//   int_addr_o       redirect target, valid with int_assert_o
// ---------------------------------------------------------------------------
module trap_seq #(
  parameter logic [63:0] MCAUSE_TIMER  = 64'h8000_0000_0000_0007,
  parameter logic [63:0] MCAUSE_ECALL  = 64'd11,
  parameter logic [63:0] MCAUSE_EBREAK = 64'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [63:0] inst_addr_i,
  input  logic        timer_int_i,
  input  logic        global_int_en_i,
  input  logic [63:0] csr_mtvec_i,
  input  logic [63:0] csr_mepc_i,
  input  logic [63:0] csr_mstatus_i,
  output logic        we_o,
  output logic [63:0] waddr_o,
  output logic [63:0] data_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [63:0] int_addr_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [63:0] CSR_MSTATUS = 64'h300;
  localparam logic [63:0] CSR_MEPC    = 64'h341;
  localparam logic [63:0] CSR_MCAUSE  = 64'h342;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MSTATUS,
    W_MCAUSE,
    W_MRET,
    JUMP
  } state_e;

  state_e      r_state;
  logic [63:0] r_epc;
  logic [63:0] r_cause;
  logic        r_ret_to_mepc;   // JUMP target select: 1 = mepc, 0 = mtvec

  logic        w_idle;
  logic        w_is_ecall;
  logic        w_is_ebreak;
  logic        w_is_mret;
  logic        w_timer_take;
  logic        w_take_trap;
  logic        w_take_mret;
  logic [63:0] w_cause;

  assign w_idle       = (r_state == IDLE);
  assign w_is_ecall   = w_idle && (inst_i == INST_ECALL);
  assign w_is_ebreak  = w_idle && (inst_i == INST_EBREAK);
  assign w_is_mret    = w_idle && (inst_i == INST_MRET);
  assign w_timer_take = w_idle && timer_int_i && global_int_en_i;

  // Synchronous exceptions beat mret, and mret beats the timer interrupt.
  // The interrupt stays pending on its input line and is seen again on the
  // first cycle back in IDLE.
  assign w_take_trap  = w_is_ecall || w_is_ebreak || (w_timer_take && !w_is_mret);
  assign w_take_mret  = w_is_mret;
  assign w_cause      = w_is_ecall  ? MCAUSE_ECALL  :
                        w_is_ebreak ? MCAUSE_EBREAK : MCAUSE_TIMER;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_epc         <= '0;
      r_cause       <= '0;
      r_ret_to_mepc <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take_trap) begin
            r_epc   <= inst_addr_i;
            r_cause <= w_cause;
            r_state <= W_MEPC;
          end else if (w_take_mret) begin
            r_state <= W_MRET;
          end
        end
        W_MEPC:    r_state <= W_MSTATUS;
        W_MSTATUS: r_state <= W_MCAUSE;
        W_MCAUSE: begin
          r_ret_to_mepc <= 1'b0;
          r_state       <= JUMP;
        end
        W_MRET: begin
          r_ret_to_mepc <= 1'b1;
          r_state       <= JUMP;
        end
        JUMP:      r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from the registered state; write data for mstatus and
  // the redirect target track the live CSR values of the current cycle.
  always_comb begin
    we_o         = 1'b0;
    waddr_o      = '0;
    data_o       = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    case (r_state)
      W_MEPC: begin
        we_o    = 1'b1;
        waddr_o = CSR_MEPC;
        data_o  = r_epc;
      end
      W_MSTATUS: begin
        we_o      = 1'b1;
        waddr_o   = CSR_MSTATUS;
        data_o    = csr_mstatus_i;
        data_o[7] = csr_mstatus_i[3];   // MPIE <= MIE
        data_o[3] = 1'b0;               // MIE  <= 0
      end
      W_MCAUSE: begin
        we_o    = 1'b1;
        waddr_o = CSR_MCAUSE;
        data_o  = r_cause;
      end
      W_MRET: begin
        we_o      = 1'b1;
        waddr_o   = CSR_MSTATUS;
        data_o    = csr_mstatus_i;
        data_o[3] = csr_mstatus_i[7];   // MIE  <= MPIE
        data_o[7] = 1'b1;               // MPIE <= 1
      end
      JUMP: begin
        int_assert_o = 1'b1;
        int_addr_o   = r_ret_to_mepc ? csr_mepc_i : csr_mtvec_i;
      end
      default: ;
    endcase
  end

  // Stall begins in the detection cycle; gated by reset so every output is
  // low while rst is asserted regardless of what sits in ID.
  assign hold_flag_o = rst && (!w_idle || w_take_trap || w_take_mret);

endmodule

// File: tb/tb_trap_seq.sv
module tb_trap_seq;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic [63:0] inst_addr_i;
  logic        timer_int_i;
  logic        global_int_en_i;
  logic [63:0] csr_mtvec_i;
  logic [63:0] csr_mepc_i;
  logic [63:0] csr_mstatus_i;
  logic        we_o;
  logic [63:0] waddr_o;
  logic [63:0] data_o;
  logic        hold_flag_o;
  logic        int_assert_o;
  logic [63:0] int_addr_o;

  always #5 clk = ~clk;

  trap_seq dut (
    .clk             (clk),
    .rst             (rst),
    .inst_i          (inst_i),
    .inst_addr_i     (inst_addr_i),
    .timer_int_i     (timer_int_i),
    .global_int_en_i (global_int_en_i),
    .csr_mtvec_i     (csr_mtvec_i),
    .csr_mepc_i      (csr_mepc_i),
    .csr_mstatus_i   (csr_mstatus_i),
    .we_o            (we_o),
    .waddr_o         (waddr_o),
    .data_o          (data_o),
    .hold_flag_o     (hold_flag_o),
    .int_assert_o    (int_assert_o),
    .int_addr_o      (int_addr_o)
  );

  // Reference model: a queue of the observable steps still owed by the
  // sequence in flight. Each step's expected outputs are derived from the
  // architectural rules when it is reached.
  typedef enum int unsigned {ST_WR_MEPC, ST_WR_MSTATUS_TRAP, ST_WR_MCAUSE,
                             ST_WR_MSTATUS_MRET, ST_JUMP_MTVEC, ST_JUMP_MEPC} step_e;
  typedef struct {
    step_e       kind;
    logic [63:0] val;
  } step_t;

  step_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic  prev_assert = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic push_trap(input logic [63:0] pc, input logic [63:0] cause);
    q.push_back('{ST_WR_MEPC, pc});
    q.push_back('{ST_WR_MSTATUS_TRAP, 64'd0});
    q.push_back('{ST_WR_MCAUSE, cause});
    q.push_back('{ST_JUMP_MTVEC, 64'd0});
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance model.
  task automatic cycle(input logic [31:0] inst, input logic [63:0] pc,
                       input logic tmr, input logic mie,
                       input logic [63:0] tvec, input logic [63:0] epc,
                       input logic [63:0] mst);
    logic        e_we, e_ia, e_hold;
    logic [63:0] e_waddr, e_data, e_iaddr;
    step_t       s;
    @(negedge clk);
    inst_i          = inst;
    inst_addr_i     = pc;
    timer_int_i     = tmr;
    global_int_en_i = mie;
    csr_mtvec_i     = tvec;
    csr_mepc_i      = epc;
    csr_mstatus_i   = mst;
    #1;
    e_we = 0; e_ia = 0; e_hold = 0; e_waddr = 0; e_data = 0; e_iaddr = 0;
    if (q.size() > 0) begin
      s = q.pop_front();
      e_hold = 1;
      case (s.kind)
        ST_WR_MEPC:         begin e_we = 1; e_waddr = 64'h341; e_data = s.val; end
        ST_WR_MSTATUS_TRAP: begin
          e_we = 1; e_waddr = 64'h300;
          e_data = (mst & ~64'h88) | (mst[3] ? 64'h80 : 64'h0);
        end
        ST_WR_MCAUSE:       begin e_we = 1; e_waddr = 64'h342; e_data = s.val; end
        ST_WR_MSTATUS_MRET: begin
          e_we = 1; e_waddr = 64'h300;
          e_data = (mst & ~64'h88) | 64'h80 | (mst[7] ? 64'h8 : 64'h0);
        end
        ST_JUMP_MTVEC:      begin e_ia = 1; e_iaddr = tvec; end
        ST_JUMP_MEPC:       begin e_ia = 1; e_iaddr = epc; end
        default: ;
      endcase
    end else begin
      if (inst == ECALL) begin
        e_hold = 1; push_trap(pc, 64'd11);
      end else if (inst == EBREAK) begin
        e_hold = 1; push_trap(pc, 64'd3);
      end else if (inst == MRET) begin
        e_hold = 1;
        q.push_back('{ST_WR_MSTATUS_MRET, 64'd0});
        q.push_back('{ST_JUMP_MEPC, 64'd0});
      end else if (tmr && mie) begin
        e_hold = 1; push_trap(pc, 64'h8000_0000_0000_0007);
      end
    end
    check_val("we",         {63'd0, we_o},         {63'd0, e_we});
    check_val("waddr",      waddr_o,               e_waddr);
    check_val("data",       data_o,                e_data);
    check_val("hold",       {63'd0, hold_flag_o},  {63'd0, e_hold});
    check_val("int_assert", {63'd0, int_assert_o}, {63'd0, e_ia});
    check_val("int_addr",   int_addr_o,            e_iaddr);
    check_val("no_double_assert", {63'd0, prev_assert & int_assert_o}, 64'd0);
    prev_assert = int_assert_o;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_we"},    {63'd0, we_o},         64'd0);
    check_val({tag, "_waddr"}, waddr_o,               64'd0);
    check_val({tag, "_data"},  data_o,                64'd0);
    check_val({tag, "_hold"},  {63'd0, hold_flag_o},  64'd0);
    check_val({tag, "_ia"},    {63'd0, int_assert_o}, 64'd0);
    check_val({tag, "_iaddr"}, int_addr_o,            64'd0);
  endtask

  initial begin
    // Reset with an ecall and an enabled interrupt presented: nothing may leak.
    rst             = 1'b0;
    inst_i          = ECALL;
    inst_addr_i     = 64'h80;
    timer_int_i     = 1'b1;
    global_int_en_i = 1'b1;
    csr_mtvec_i     = 64'h200;
    csr_mepc_i      = 64'h108;
    csr_mstatus_i   = 64'h8;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    inst_i = NOP; timer_int_i = 1'b0;
    rst = 1'b1;

    // ecall at 0x80, mtvec 0x200, mstatus 0x8
    cycle(ECALL, 64'h80, 0, 1, 64'h200, 64'h108, 64'h8);
    for (int unsigned i = 0; i < 5; i++) cycle(NOP, 64'h84, 0, 1, 64'h200, 64'h108, 64'h8);

    // timer with MIE set at 0x104, then with MIE clear
    cycle(NOP, 64'h104, 1, 1, 64'h200, 64'h108, 64'h8);
    for (int unsigned i = 0; i < 4; i++) cycle(NOP, 64'h108, 0, 1, 64'h200, 64'h108, 64'h0);
    for (int unsigned i = 0; i < 3; i++) cycle(NOP, 64'h104, 1, 0, 64'h200, 64'h108, 64'h8);

    // mret with mstatus 0x80, mepc 0x108
    cycle(MRET, 64'h300, 0, 0, 64'h200, 64'h108, 64'h80);
    for (int unsigned i = 0; i < 3; i++) cycle(NOP, 64'h304, 0, 0, 64'h200, 64'h108, 64'h80);

    // ebreak coincident with timer; MIE stays set so the interrupt follows
    cycle(EBREAK, 64'h400, 1, 1, 64'h200, 64'h108, 64'h8);
    for (int unsigned i = 0; i < 10; i++) cycle(NOP, 64'h404, 1, 1, 64'h200, 64'h108, 64'h8);
    // same, MIE dropped before return: interrupt not taken
    cycle(EBREAK, 64'h500, 1, 1, 64'h200, 64'h108, 64'h8);
    for (int unsigned i = 0; i < 6; i++) cycle(NOP, 64'h504, 1, 0, 64'h200, 64'h108, 64'h0);

    // ecall coincident with timer, interrupt taken afterwards
    cycle(ECALL, 64'h600, 1, 1, 64'h200, 64'h108, 64'h8);
    for (int unsigned i = 0; i < 9; i++) cycle(NOP, 64'h604, 1, 1, 64'h200, 64'h108, 64'h8);
    for (int unsigned i = 0; i < 2; i++) cycle(NOP, 64'h604, 0, 1, 64'h200, 64'h108, 64'h8);

    // back-to-back: ecall then mret on the first IDLE cycle
    cycle(ECALL, 64'h700, 0, 1, 64'h200, 64'h108, 64'h8);
    for (int unsigned i = 0; i < 5; i++) cycle(MRET, 64'h704, 0, 1, 64'h200, 64'h700, 64'h80);
    for (int unsigned i = 0; i < 3; i++) cycle(NOP, 64'h708, 0, 1, 64'h200, 64'h700, 64'h80);

    // asynchronous reset while in W_MSTATUS
    cycle(ECALL, 64'h800, 0, 1, 64'h200, 64'h108, 64'h8);
    cycle(NOP, 64'h804, 0, 1, 64'h200, 64'h108, 64'h8);
    cycle(NOP, 64'h804, 0, 1, 64'h200, 64'h108, 64'h8);
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    q.delete();
    prev_assert = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int unsigned i = 0; i < 6; i++) cycle(NOP, 64'h900, 0, 1, 64'h200, 64'h108, 64'h8);

    // randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      logic [31:0] inst;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       inst = ECALL;
        1:       inst = EBREAK;
        2:       inst = MRET;
        default: inst = $urandom();
      endcase
      cycle(inst, {$urandom(), $urandom()}, 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), {$urandom(), $urandom()},
            {$urandom(), $urandom()}, {$urandom(), $urandom()});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_seq.md
TRAP_SEQ -- requirements
Module: trap_seq

Interface
REQ-001 SHALL have parameter MCAUSE_TIMER, default 64'h8000_0000_0000_0007, mcause value for a machine timer interrupt.
REQ-002 SHALL have parameter MCAUSE_ECALL, default 64'd11, mcause value for ecall.
REQ-003 SHALL have parameter MCAUSE_EBREAK, default 64'd3, mcause value for ebreak.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port inst_i  input  32  instruction currently in the ID stage.
REQ-007 SHALL have port inst_addr_i  input  64  PC of inst_i.
REQ-008 SHALL have port timer_int_i  input  1  level-sensitive timer interrupt request.
REQ-009 SHALL have port global_int_en_i  input  1  mstatus.MIE from the CSR file.
REQ-010 SHALL have port csr_mtvec_i  input  64  current mtvec.
REQ-011 SHALL have port csr_mepc_i  input  64  current mepc.
REQ-012 SHALL have port csr_mstatus_i  input  64  current mstatus.
REQ-013 SHALL have port we_o  output  1  CSR write enable to the CSR file's CLINT port.
REQ-014 SHALL have port waddr_o  output  64  CSR write address; only bits [11:0] are non-zero.
REQ-015 SHALL have port data_o  output  64  CSR write data.
REQ-016 SHALL have port hold_flag_o  output  1  pipeline stall request.
REQ-017 SHALL have port int_assert_o  output  1  one-cycle redirect strobe.
REQ-018 SHALL have port int_addr_o  output  64  redirect target, valid while int_assert_o=1.

Function
REQ-019 SHALL implement states IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_MRET and JUMP.
REQ-020 SHALL decode only while in IDLE: ecall = 32'h0000_0073, ebreak = 32'h0010_0073, mret = 32'h3020_0073.
REQ-021 SHALL apply trap priority ecall/ebreak > mret > timer interrupt.
REQ-022 SHALL take a timer interrupt only when timer_int_i=1 AND global_int_en_i=1.
REQ-023 SHALL, on trap detection in IDLE, capture epc_q<=inst_addr_i and cause_q<=the matching MCAUSE_* value, then go to W_MEPC.
REQ-024 SHALL, in W_MEPC, drive we_o=1, waddr_o=0x341, data_o=epc_q, then go to W_MSTATUS.
REQ-025 SHALL, in W_MSTATUS, drive we_o=1, waddr_o=0x300, and data_o=csr_mstatus_i with bit7 set to csr_mstatus_i[3] and bit3 cleared, then go to W_MCAUSE.
REQ-026 SHALL, in W_MCAUSE, drive we_o=1, waddr_o=0x342, data_o=cause_q, then go to JUMP with target select = mtvec.
REQ-027 SHALL, on mret detection in IDLE, go to W_MRET.
REQ-028 SHALL, in W_MRET, drive we_o=1, waddr_o=0x300, and data_o=csr_mstatus_i with bit3 set to csr_mstatus_i[7] and bit7 set to 1, then go to JUMP with target select = mepc.
REQ-029 SHALL, in JUMP, drive int_assert_o=1 for exactly one cycle with int_addr_o=csr_mtvec_i (trap) or csr_mepc_i (mret), then return to IDLE.
REQ-030 SHALL drive we_o=0, waddr_o=0, data_o=0, int_assert_o=0 and int_addr_o=0 in every state not listed above.
REQ-031 SHALL drive hold_flag_o combinationally as (state != IDLE) OR (trap or mret detected in IDLE), so the stall starts in the detection cycle.
REQ-032 SHALL complete trap entry from detection to redirect strobe in 4 cycles, and mret in 2 cycles.
REQ-033 SHALL ignore timer_int_i and inst_i in every non-IDLE state; a request held pending is evaluated again on the first cycle back in IDLE.
REQ-034 SHALL, when ecall and timer_int_i coincide, take the ecall (cause 11) and leave the interrupt pending.

Reset
REQ-035 SHALL, while rst=0 (independent of clk), force state=IDLE, epc_q=0, cause_q=0, and all outputs to 0.
REQ-036 SHALL abandon a sequence when reset asserts mid-sequence, with no further CSR writes issued after reset deasserts.

Verification
REQ-037 ecall at PC 0x80 with mtvec=0x200 and mstatus=0x8 SHALL produce:
  - cycle 1: write 0x341 <= 0x80;
  - cycle 2: write 0x300 <= 0x80;
  - cycle 3: write 0x342 <= 11;
  - cycle 4: int_assert_o=1, int_addr_o=0x200;
  - hold_flag_o=1 over cycles 0-4.
REQ-038 timer_int_i=1 with global_int_en_i=1 at PC 0x104 SHALL write mcause 0x8000_0000_0000_0007 and mepc 0x104; with global_int_en_i=0 it SHALL produce no write and hold_flag_o=0.
REQ-039 mret with mstatus=0x80 and mepc=0x108 SHALL produce write 0x300 <= 0x88, then int_assert_o=1 with int_addr_o=0x108.
REQ-040 ebreak and timer_int_i asserted in the same cycle SHALL take cause 3 first; the interrupt is then taken only if global_int_en_i=1 on return to IDLE.
REQ-041 rst=0 asserted during W_MSTATUS SHALL force all outputs to 0 asynchronously, and after release the block SHALL stay in IDLE with no writes.
REQ-042 A back-to-back sequence (ecall immediately followed by mret) SHALL produce the exact 4+2 cycle write pattern, with int_assert_o never asserted for two consecutive cycles.
